fetch_sequencer: RTL and testbench

- Fetch-stage controller for the 32-bit program counter register: computes that register's next_PC every cycle and sequences instruction-memory fetches.
- Keeps at most one fetch outstanding on a req/gnt + rvalid memory handshake.
- Buffers one fetched instruction for decode.
- Arbitrates next-PC sources. Priority, highest first: trap, then branch/jump redirect, then sequential PC+4, then hold.

---
 rtl/fetch_sequencer_if.sv | 30 +++
 rtl/fetch_sequencer.sv | 61 ++++++
 tb/tb_fetch_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch-stage bundle (PC register, imem req/gnt/rvalid, decode buffer, redirect/trap)
// master: the fetch sequencer; slave: its environment (PC register, memory, decode, trap unit).
interface fetch_sequencer_if;
  logic [31:0] current_pc;
  logic [31:0] next_pc;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_gnt;
  logic imem_rvalid;
  logic [31:0] imem_rdata;
  logic inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic inst_ready;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic trap_valid;
  logic [31:0] trap_pc;
  logic fetch_misalign;
  modport master(
    input current_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input redirect_valid, redirect_pc, trap_valid, trap_pc,
    output next_pc, imem_req, imem_addr, inst_valid, inst_data, inst_pc, fetch_misalign
  );
  modport slave(
    output current_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output redirect_valid, redirect_pc, trap_valid, trap_pc,
    input next_pc, imem_req, imem_addr, inst_valid, inst_data, inst_pc, fetch_misalign
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next-PC arbitration (trap > redirect > PC+PC_INC > hold) and single-outstanding fetch with a one-entry decode buffer
// Ports: clk, rst (async, active-high), bus (fetch_sequencer_if.master).
// Optional: MISALIGN_TRAP_EN makes misaligned redirects not taken and pulses fetch_misalign.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_INC = 32'd4
) (
  input logic clk,
  input logic rst,
  fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {REQ, WAIT_RSP, HOLD, KILL} state_t;
  state_t state, state_nx;
  logic flush, take, misalign;
  logic [31:0] redir_pc;
  assign flush = bus.trap_valid | bus.redirect_valid;
`ifdef MISALIGN_TRAP_EN
  assign misalign = bus.redirect_valid & ~bus.trap_valid & (|bus.redirect_pc[1:0]);
  assign redir_pc = bus.redirect_pc;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^bus.redirect_pc[1:0];
  assign misalign = 1'b0;
  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
`endif
  assign take = (state == WAIT_RSP) & bus.imem_rvalid & ~flush;
  assign bus.imem_req = (state == REQ) & ~flush;
  assign bus.imem_addr = bus.current_pc;
  assign bus.inst_valid = (state == HOLD);
  always_comb begin
    bus.next_pc = bus.trap_valid ? bus.trap_pc :
                  bus.redirect_valid ? (misalign ? bus.current_pc : redir_pc) :
                  ((state == HOLD) & bus.inst_ready) ? bus.current_pc + PC_INC :
                  bus.current_pc;
  end
  always_comb begin
    state_nx = state;
    case (state)
      REQ: state_nx = (~flush & bus.imem_gnt) ? WAIT_RSP : REQ;
      WAIT_RSP: state_nx = bus.imem_rvalid ? (flush ? REQ : HOLD) : (flush ? KILL : WAIT_RSP);
      HOLD: state_nx = (flush | bus.inst_ready) ? REQ : HOLD;
      KILL: state_nx = bus.imem_rvalid ? REQ : KILL;
      default: state_nx = REQ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REQ;
      bus.inst_data <= '0;
      bus.inst_pc <= RESET_PC;
      bus.fetch_misalign <= 1'b0;
    end else begin
      state <= state_nx;
      bus.fetch_misalign <= misalign;
      if (take) begin
        bus.inst_data <= bus.imem_rdata;
        bus.inst_pc <= bus.current_pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random and directed stimulus with a queue scoreboard of expected delivered instructions
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_sequencer_if bus();
  fetch_sequencer dut(.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] pc_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_reg <= RESET_PC;
    else pc_reg <= bus.next_pc;
  end
  assign bus.current_pc = pc_reg;
  int checks = 0;
  int fails = 0;
  int delivered = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] mon_e;
  logic pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic prev_v = 1'b0;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic t, input logic [31:0] tp, input logic r, input logic [31:0] rp,
                      input logic rdy, input logic ga, input logic ra);
    logic rv, g;
    logic [31:0] tgt, nx;
    @(negedge clk);
    bus.trap_valid = t;
    bus.trap_pc = tp;
    bus.redirect_valid = r;
    bus.redirect_pc = rp;
    bus.inst_ready = rdy;
    rv = pend & ra;
    bus.imem_rvalid = rv;
    bus.imem_rdata = rv ? word_at(pend_addr) : 32'hDEAD_BEEF;
    #1;
    g = bus.imem_req & ga;
    bus.imem_gnt = g;
    #1;
`ifdef MISALIGN_TRAP_EN
    tgt = t ? tp : (rp[1:0] != 2'b00) ? pc_reg : rp;
`else
    tgt = t ? tp : {rp[31:2], 2'b00};
`endif
    nx = (t | r) ? tgt : (bus.inst_valid & rdy) ? pc_reg + 32'd4 : pc_reg;
    chk("next_pc", bus.next_pc, nx);
    chk("imem_addr", bus.imem_addr, pc_reg);
    if (t | r | bus.inst_valid) chk("imem_req_quiet", 32'(bus.imem_req), 32'd0);
    if (g & ~rv) chk("one_outstanding", 32'(pend), 32'd0);
    if (t | r) begin
      model_pc = tgt;
      exp_q.delete();
      exp_q.push_back(tgt);
    end else if (bus.inst_valid & rdy) begin
      model_pc = model_pc + 32'd4;
      exp_q.push_back(model_pc);
    end
    if (rv) pend = 1'b0;
    if (g) begin
      pend = 1'b1;
      pend_addr = bus.imem_addr;
    end
  endtask
  task automatic idle(input logic rdy, input logic ga, input logic ra);
    step(1'b0, 32'h0, 1'b0, 32'h0, rdy, ga, ra);
  endtask
  always @(posedge clk) begin
    #1;
    if (rst) prev_v = 1'b0;
    else begin
      if (bus.inst_valid & ~prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL inst_unexpected: got pc %h with no instruction expected", bus.inst_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("inst_pc", bus.inst_pc, mon_e);
          chk("inst_data", bus.inst_data, word_at(mon_e));
          delivered++;
        end
      end
      prev_v = bus.inst_valid;
    end
  end
  initial begin
    bus.trap_valid = 1'b0;
    bus.trap_pc = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, RESET_PC);
    chk("rst_misalign", 32'(bus.fetch_misalign), 32'd0);
    chk("rst_next_pc", bus.next_pc, RESET_PC);
    rst = 1'b0;
    model_pc = RESET_PC;
    exp_q.push_back(RESET_PC);
    idle(1'b1, 1'b1, 1'b1);
    chk("t1_req", 32'(bus.imem_req), 32'd1);
    chk("t1_addr0", bus.imem_addr, 32'h8000_0000);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b1);
    chk("t1_valid", 32'(bus.inst_valid), 32'd1);
    chk("t1_inst_pc", bus.inst_pc, 32'h8000_0000);
    chk("t1_next_pc", bus.next_pc, 32'h8000_0004);
    idle(1'b1, 1'b1, 1'b1);
    chk("t1_req2", 32'(bus.imem_req), 32'd1);
    chk("t1_addr1", bus.imem_addr, 32'h8000_0004);
    step(1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    chk("t2_kill_valid", 32'(bus.inst_valid), 32'd0);
    chk("t2_kill_req", 32'(bus.imem_req), 32'd0);
    idle(1'b1, 1'b1, 1'b1);
    chk("t2_stale_valid", 32'(bus.inst_valid), 32'd0);
    idle(1'b1, 1'b1, 1'b1);
    chk("t2_drop_valid", 32'(bus.inst_valid), 32'd0);
    chk("t2_req", 32'(bus.imem_req), 32'd1);
    chk("t2_addr", bus.imem_addr, 32'h8000_0100);
    idle(1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h8000_0040, 1'b1, 32'h8000_0200, 1'b0, 1'b1, 1'b1);
    chk("t3_next_pc", bus.next_pc, 32'h8000_0040);
    idle(1'b0, 1'b1, 1'b1);
    chk("t3_valid_cleared", 32'(bus.inst_valid), 32'd0);
    chk("t3_addr", bus.imem_addr, 32'h8000_0040);
    idle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0, 1'b1, 1'b1);
      chk("t4_valid", 32'(bus.inst_valid), 32'd1);
      chk("t4_inst_pc", bus.inst_pc, 32'h8000_0040);
      chk("t4_inst_data", bus.inst_data, word_at(32'h8000_0040));
      chk("t4_req", 32'(bus.imem_req), 32'd0);
      chk("t4_hold_pc", bus.next_pc, 32'h8000_0040);
    end
    idle(1'b1, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b1);
    chk("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b0, 1'b1);
    chk("t5_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    chk("t5_wrap", bus.next_pc, 32'h0000_0000);
    idle(1'b1, 1'b0, 1'b1);
    chk("t5_addr_wrap", bus.imem_addr, 32'h0000_0000);
    step(1'b0, 32'h0, 1'b1, 32'h8000_0102, 1'b1, 1'b0, 1'b1);
`ifdef MISALIGN_TRAP_EN
    chk("t6_next_pc", bus.next_pc, 32'h0000_0000);
    idle(1'b1, 1'b0, 1'b1);
    chk("t6_misalign_pulse", 32'(bus.fetch_misalign), 32'd1);
    chk("t6_addr", bus.imem_addr, 32'h0000_0000);
`else
    chk("t6_next_pc", bus.next_pc, 32'h8000_0100);
    idle(1'b1, 1'b0, 1'b1);
    chk("t6_misalign_pulse", 32'(bus.fetch_misalign), 32'd0);
    chk("t6_addr", bus.imem_addr, 32'h8000_0100);
`endif
    idle(1'b1, 1'b0, 1'b1);
    chk("t6_misalign_end", 32'(bus.fetch_misalign), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 100) < 4, $urandom & 32'hFFFF_FFFC, ($urandom % 100) < 8, $urandom,
           1'($urandom % 2), ($urandom % 100) < 60, ($urandom % 100) < 60);
    end
    repeat (20) idle(1'b1, 1'b1, 1'b1);
    chk("delivered_min", 32'(delivered >= 50), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
